// File: rtl/piece_mover.sv
// Falling-piece position controller: arbitrates user and gravity move requests,
// runs one collision check per request and commits or lands the piece.
module piece_mover #(
    parameter int GRAVITY_TICKS = 25000000,
    parameter int SPAWN_X       = 6,
    parameter int SPAWN_Y       = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       spawn,
    input  logic [1:0] blockType,
    input  logic       moveLeft,
    input  logic       moveRight,
    input  logic       moveDown,
    input  logic       canMove,
    output logic       checkEnable,
    output logic [1:0] checkDir,
    output logic [3:0] XPOS,
    output logic [4:0] YPOS,
    output logic [1:0] currentBlock,
    output logic       active,
    output logic       landed
);
    localparam int CW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(GRAVITY_TICKS - 1);

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    typedef enum logic [1:0] {EMPTY, IDLE, REQ, EVAL} state_t;

    state_t        state_reg;
    logic [CW-1:0] grav_cnt_reg;
    logic          pending_reg;

    logic grav_tick;
    logic user_down;
    logic down_req;

    // A down request is only issued from IDLE when no higher-priority
    // horizontal request wins the arbitration in the same cycle.
    always_comb begin
        grav_tick = active && (grav_cnt_reg == CNT_MAX);
        user_down = (state_reg == IDLE) && moveDown && !moveLeft && !moveRight;
        down_req  = (state_reg == IDLE) && !moveLeft && !moveRight
                    && (moveDown || pending_reg);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg    <= EMPTY;
            grav_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            XPOS         <= '0;
            YPOS         <= '0;
            currentBlock <= '0;
            checkEnable  <= 1'b0;
            checkDir     <= DIR_LEFT;
            active       <= 1'b0;
            landed       <= 1'b0;
        end else begin
            landed      <= 1'b0;
            checkEnable <= 1'b0;

            if (active) begin
                if (user_down || grav_tick)
                    grav_cnt_reg <= '0;
                else
                    grav_cnt_reg <= grav_cnt_reg + 1'b1;
                // A fresh tick outranks the clear so it is never lost.
                if (grav_tick && !user_down)
                    pending_reg <= 1'b1;
                else if (down_req)
                    pending_reg <= 1'b0;
            end

            case (state_reg)
                EMPTY: begin
                    if (spawn) begin
                        XPOS         <= 4'(SPAWN_X);
                        YPOS         <= 5'(SPAWN_Y);
                        currentBlock <= blockType;
                        grav_cnt_reg <= '0;
                        pending_reg  <= 1'b0;
                        active       <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                IDLE: begin
                    if (moveLeft) begin
                        checkDir    <= DIR_LEFT;
                        checkEnable <= 1'b1;
                        state_reg   <= REQ;
                    end else if (moveRight) begin
                        checkDir    <= DIR_RIGHT;
                        checkEnable <= 1'b1;
                        state_reg   <= REQ;
                    end else if (moveDown || pending_reg) begin
                        checkDir    <= DIR_DOWN;
                        checkEnable <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    state_reg <= EVAL;
                end
                EVAL: begin
                    state_reg <= IDLE;
                    if (canMove) begin
                        case (checkDir)
                            DIR_LEFT:  XPOS <= XPOS - 1'b1;
                            DIR_RIGHT: XPOS <= XPOS + 1'b1;
                            DIR_DOWN:  YPOS <= YPOS + 1'b1;
                            default:   ;
                        endcase
                    end else if (checkDir == DIR_DOWN) begin
                        landed    <= 1'b1;
                        active    <= 1'b0;
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_mover.sv
// Directed self-checking bench for piece_mover: user moves, arbitration,
// landing, gravity timing and asynchronous reset.
module tb_piece_mover;
    logic       Clock;
    logic       Reset;
    logic       spawn;
    logic [1:0] blockType;
    logic       moveLeft, moveRight, moveDown, canMove;
    logic       checkEnable;
    logic [1:0] checkDir;
    logic [3:0] XPOS;
    logic [4:0] YPOS;
    logic [1:0] currentBlock;
    logic       active, landed;

    logic       g_spawn, g_canMove, g_zero;
    logic       g_checkEnable;
    logic [1:0] g_checkDir;
    logic [3:0] g_XPOS;
    logic [4:0] g_YPOS;
    logic [1:0] g_currentBlock;
    logic       g_active, g_landed;

    int total = 0;
    int bad   = 0;

    piece_mover #(.GRAVITY_TICKS(1000), .SPAWN_X(6), .SPAWN_Y(0)) dut (
        .Clock(Clock), .Reset(Reset), .spawn(spawn), .blockType(blockType),
        .moveLeft(moveLeft), .moveRight(moveRight), .moveDown(moveDown),
        .canMove(canMove), .checkEnable(checkEnable), .checkDir(checkDir),
        .XPOS(XPOS), .YPOS(YPOS), .currentBlock(currentBlock),
        .active(active), .landed(landed)
    );

    piece_mover #(.GRAVITY_TICKS(4), .SPAWN_X(6), .SPAWN_Y(0)) dut_g (
        .Clock(Clock), .Reset(Reset), .spawn(g_spawn), .blockType(2'b01),
        .moveLeft(g_zero), .moveRight(g_zero), .moveDown(g_zero),
        .canMove(g_canMove), .checkEnable(g_checkEnable), .checkDir(g_checkDir),
        .XPOS(g_XPOS), .YPOS(g_YPOS), .currentBlock(g_currentBlock),
        .active(g_active), .landed(g_landed)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic do_spawn(input logic [1:0] bt);
        blockType = bt;
        spawn = 1'b1;
        tick();
        spawn = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (XPOS !== 4'd0) begin bad++; $display("FAIL reset_xpos got=%0d exp=0", XPOS); end
        if (YPOS !== 5'd0) begin bad++; $display("FAIL reset_ypos got=%0d exp=0", YPOS); end
        if (currentBlock !== 2'd0) begin bad++; $display("FAIL reset_block got=%0d exp=0", currentBlock); end
        if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0d exp=0", active); end
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL reset_ce got=%0d exp=0", checkEnable); end
        if (checkDir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", checkDir); end
        if (landed !== 1'b0) begin bad++; $display("FAIL reset_landed got=%0d exp=0", landed); end
        // Moves in EMPTY must not start a check
        moveLeft = 1'b1; tick(); moveLeft = 1'b0;
        total++;
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL empty_move_ce got=%0d exp=0", checkEnable); end
        $display("test_reset: x=%0d y=%0d active=%0d", XPOS, YPOS, active);
    endtask

    task automatic test_spawn();
        do_spawn(2'b10);
        total += 4;
        if (XPOS !== 4'd6) begin bad++; $display("FAIL spawn_xpos got=%0d exp=6", XPOS); end
        if (YPOS !== 5'd0) begin bad++; $display("FAIL spawn_ypos got=%0d exp=0", YPOS); end
        if (currentBlock !== 2'b10) begin bad++; $display("FAIL spawn_block got=%0d exp=2", currentBlock); end
        if (active !== 1'b1) begin bad++; $display("FAIL spawn_active got=%0d exp=1", active); end
        $display("test_spawn: x=%0d y=%0d block=%0d", XPOS, YPOS, currentBlock);
    endtask

    task automatic test_move_left();
        moveLeft = 1'b1; tick(); moveLeft = 1'b0;
        total += 3;
        if (checkEnable !== 1'b1) begin bad++; $display("FAIL left_ce got=%0d exp=1", checkEnable); end
        if (checkDir !== 2'b00) begin bad++; $display("FAIL left_dir got=%0d exp=0", checkDir); end
        if (XPOS !== 4'd6) begin bad++; $display("FAIL left_xpos_req got=%0d exp=6", XPOS); end
        canMove = 1'b1; tick();
        total += 3;
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL left_ce_eval got=%0d exp=0", checkEnable); end
        if (checkDir !== 2'b00) begin bad++; $display("FAIL left_dir_eval got=%0d exp=0", checkDir); end
        if (XPOS !== 4'd6) begin bad++; $display("FAIL left_xpos_eval got=%0d exp=6", XPOS); end
        tick(); canMove = 1'b0;
        total++;
        if (XPOS !== 4'd5) begin bad++; $display("FAIL left_xpos_commit got=%0d exp=5", XPOS); end
        $display("test_move_left: x=%0d", XPOS);
    endtask

    task automatic test_spawn_ignored();
        do_spawn(2'b00);
        total += 2;
        if (currentBlock !== 2'b10) begin bad++; $display("FAIL respawn_block got=%0d exp=2", currentBlock); end
        if (XPOS !== 4'd5) begin bad++; $display("FAIL respawn_xpos got=%0d exp=5", XPOS); end
        $display("test_spawn_ignored: x=%0d block=%0d", XPOS, currentBlock);
    endtask

    task automatic test_left_right_same();
        do_reset();
        do_spawn(2'b11);
        moveLeft = 1'b1; moveRight = 1'b1; tick(); moveLeft = 1'b0; moveRight = 1'b0;
        total += 2;
        if (checkEnable !== 1'b1) begin bad++; $display("FAIL lr_ce got=%0d exp=1", checkEnable); end
        if (checkDir !== 2'b00) begin bad++; $display("FAIL lr_dir got=%0d exp=0", checkDir); end
        canMove = 1'b0; tick(); tick();
        total++;
        if (XPOS !== 4'd6) begin bad++; $display("FAIL lr_xpos got=%0d exp=6", XPOS); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (checkEnable !== 1'b0) begin bad++; $display("FAIL lr_no_right_ce got=%0d exp=0", checkEnable); end
        end
        $display("test_left_right_same: x=%0d dir=%0d", XPOS, checkDir);
    endtask

    task automatic test_right_down();
        moveRight = 1'b1; tick(); moveRight = 1'b0;
        total++;
        if (checkDir !== 2'b01) begin bad++; $display("FAIL right_dir got=%0d exp=1", checkDir); end
        canMove = 1'b1; tick(); tick(); canMove = 1'b0;
        total++;
        if (XPOS !== 4'd7) begin bad++; $display("FAIL right_xpos got=%0d exp=7", XPOS); end
        moveDown = 1'b1; tick(); moveDown = 1'b0;
        total++;
        if (checkDir !== 2'b10) begin bad++; $display("FAIL down_dir got=%0d exp=2", checkDir); end
        canMove = 1'b1; tick(); tick(); canMove = 1'b0;
        total += 2;
        if (YPOS !== 5'd1) begin bad++; $display("FAIL down_ypos got=%0d exp=1", YPOS); end
        if (XPOS !== 4'd7) begin bad++; $display("FAIL down_xpos got=%0d exp=7", XPOS); end
        $display("test_right_down: x=%0d y=%0d", XPOS, YPOS);
    endtask

    task automatic test_ignored_in_req();
        moveRight = 1'b1; tick(); moveRight = 1'b0;
        moveLeft = 1'b1; tick(); moveLeft = 1'b0;
        canMove = 1'b1; tick(); canMove = 1'b0;
        total++;
        if (XPOS !== 4'd8) begin bad++; $display("FAIL req_ignore_xpos got=%0d exp=8", XPOS); end
        tick();
        total++;
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL req_ignore_ce got=%0d exp=0", checkEnable); end
        $display("test_ignored_in_req: x=%0d", XPOS);
    endtask

    task automatic test_landing();
        do_reset();
        do_spawn(2'b01);
        for (int i = 0; i < 16; i++) begin
            moveDown = 1'b1; tick(); moveDown = 1'b0;
            canMove = 1'b1; tick(); tick(); canMove = 1'b0;
        end
        total++;
        if (YPOS !== 5'd16) begin bad++; $display("FAIL land_pre_ypos got=%0d exp=16", YPOS); end
        moveDown = 1'b1; tick(); moveDown = 1'b0;
        canMove = 1'b0; tick(); tick();
        total += 3;
        if (landed !== 1'b1) begin bad++; $display("FAIL land_pulse got=%0d exp=1", landed); end
        if (active !== 1'b0) begin bad++; $display("FAIL land_active got=%0d exp=0", active); end
        if (YPOS !== 5'd16) begin bad++; $display("FAIL land_ypos got=%0d exp=16", YPOS); end
        moveLeft = 1'b1; tick(); moveLeft = 1'b0;
        total += 2;
        if (landed !== 1'b0) begin bad++; $display("FAIL land_pulse_end got=%0d exp=0", landed); end
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL land_move_ce got=%0d exp=0", checkEnable); end
        canMove = 1'b1; tick(); tick(); canMove = 1'b0;
        total++;
        if (XPOS !== 4'd6) begin bad++; $display("FAIL land_move_xpos got=%0d exp=6", XPOS); end
        $display("test_landing: y=%0d active=%0d", YPOS, active);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        do_spawn(2'b10);
        moveRight = 1'b1; tick(); moveRight = 1'b0;
        total++;
        if (checkEnable !== 1'b1) begin bad++; $display("FAIL rst_req_ce_pre got=%0d exp=1", checkEnable); end
        canMove = 1'b1;
        Reset = 1'b1;
        #1;
        total += 4;
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL rst_async_ce got=%0d exp=0", checkEnable); end
        if (XPOS !== 4'd0) begin bad++; $display("FAIL rst_async_xpos got=%0d exp=0", XPOS); end
        if (active !== 1'b0) begin bad++; $display("FAIL rst_async_active got=%0d exp=0", active); end
        if (currentBlock !== 2'd0) begin bad++; $display("FAIL rst_async_block got=%0d exp=0", currentBlock); end
        tick();
        Reset = 1'b0;
        tick(); tick(); tick();
        canMove = 1'b0;
        total += 3;
        if (XPOS !== 4'd0) begin bad++; $display("FAIL rst_after_xpos got=%0d exp=0", XPOS); end
        if (active !== 1'b0) begin bad++; $display("FAIL rst_after_active got=%0d exp=0", active); end
        if (checkEnable !== 1'b0) begin bad++; $display("FAIL rst_after_ce got=%0d exp=0", checkEnable); end
        $display("test_reset_mid_req: x=%0d active=%0d", XPOS, active);
    endtask

    task automatic test_gravity();
        int exp_y;
        logic exp_ce;
        do_reset();
        g_canMove = 1'b1;
        g_spawn = 1'b1; tick(); g_spawn = 1'b0;
        // Spawn edge is cycle 0: checks start at 5 then every 4; commits at 7, 11, ...
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_ce = (k >= 5) && (((k - 5) % 4) == 0);
            exp_y  = (k < 7) ? 0 : ((k - 7) / 4 + 1);
            total += 2;
            if (g_checkEnable !== exp_ce) begin bad++; $display("FAIL grav_ce cyc=%0d got=%0d exp=%0d", k, g_checkEnable, exp_ce); end
            if (g_YPOS !== 5'(exp_y)) begin bad++; $display("FAIL grav_ypos cyc=%0d got=%0d exp=%0d", k, g_YPOS, exp_y); end
            if (exp_ce) begin
                total++;
                if (g_checkDir !== 2'b10) begin bad++; $display("FAIL grav_dir cyc=%0d got=%0d exp=2", k, g_checkDir); end
            end
        end
        $display("test_gravity: y=%0d", g_YPOS);
    endtask

    initial begin
        Reset = 1'b1; spawn = 1'b0; blockType = 2'b00;
        moveLeft = 1'b0; moveRight = 1'b0; moveDown = 1'b0; canMove = 1'b0;
        g_spawn = 1'b0; g_canMove = 1'b0; g_zero = 1'b0;
        test_reset();
        test_spawn();
        test_move_left();
        test_spawn_ignored();
        test_left_right_same();
        test_right_down();
        test_ignored_in_req();
        test_landing();
        test_reset_mid_req();
        test_gravity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter GRAVITY_TICKS, default 25000000, Clock cycles between automatic down requests.
REQ-002 SHALL have parameter SPAWN_X, default 6, XPOS loaded on spawn.
REQ-003 SHALL have parameter SPAWN_Y, default 0, YPOS loaded on spawn.
REQ-004 SHALL have port Clock, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port spawn, input, 1, one-cycle request to place a new piece.
REQ-007 SHALL have port blockType, input, 2, piece type captured on spawn (00 J2, 01 S2, 10 O, 11 I1).
REQ-008 SHALL have ports moveLeft, moveRight, moveDown, input, 1 each, one-cycle user move requests.
REQ-009 SHALL have port canMove, input, 1, registered result from the selected collision checker.
REQ-010 SHALL have port checkEnable, output, 1, Enable strobe to the collision checkers.
REQ-011 SHALL have port checkDir, output, 2, checker select: 00 left, 01 right, 10 down, 11 unused.
REQ-012 SHALL have ports XPOS output 4, YPOS output 5, currentBlock output 2, the committed piece position and type, also driven to the checkers.
REQ-013 SHALL have port active, output, 1, high while a piece is on the board.
REQ-014 SHALL have port landed, output, 1, one-cycle pulse when a down check fails.

Function
REQ-015 SHALL implement FSM states EMPTY, IDLE, REQ, EVAL.
REQ-016 EMPTY: active=0; spawn=1 loads XPOS=SPAWN_X, YPOS=SPAWN_Y, currentBlock=blockType, clears gravity counter and pending flag, next state IDLE.
REQ-017 IDLE: active=1; a request present selects checkDir and goes to REQ; otherwise stays.
REQ-018 Request priority in IDLE: moveLeft > moveRight > moveDown/gravity pending; lower-priority simultaneous user requests are dropped.
REQ-019 REQ: checkEnable=1 for exactly one cycle, checkDir held; next state EVAL.
REQ-020 EVAL: canMove sampled (checker result registered on the REQ edge); checkEnable=0; next state IDLE unless landing.
REQ-021 EVAL with canMove=1: left XPOS-1, right XPOS+1, down YPOS+1, committed on the EVAL edge.
REQ-022 EVAL with canMove=0: left/right leave position unchanged; down asserts landed for one cycle and goes to EMPTY.
REQ-023 checkDir and XPOS/YPOS/currentBlock SHALL remain stable from entering REQ through EVAL.
REQ-024 User move requests arriving in REQ, EVAL or EMPTY SHALL be ignored (no queuing).
REQ-025 Gravity counter counts Clock cycles while active; at GRAVITY_TICKS-1 it wraps to 0 and sets gravity pending.
REQ-026 Gravity pending persists until a down request is issued (moveDown or pending) from IDLE, then clears; a second tick while pending is absorbed.
REQ-027 A moveDown-initiated down request SHALL also clear gravity pending and restart the counter at 0.
REQ-028 spawn while active SHALL be ignored.
REQ-029 Arithmetic SHALL not wrap: boundary rejection relies on the checker; XPOS/YPOS change only on canMove=1.

Reset
REQ-030 Reset=1 SHALL immediately force state EMPTY, XPOS=0, YPOS=0, currentBlock=0, checkEnable=0, checkDir=00, active=0, landed=0, counter=0, pending=0.
REQ-031 Reset mid-REQ or mid-EVAL SHALL abandon the move without committing; after deassertion only spawn leaves EMPTY.

Verification
REQ-032 Reset, spawn with blockType=10 -> next cycle XPOS=6, YPOS=0, currentBlock=10, active=1.
REQ-033 IDLE, moveLeft pulse, canMove=1 in EVAL -> checkEnable high one cycle with checkDir=00, XPOS 6->5 two cycles after request.
REQ-034 moveLeft and moveRight same cycle, canMove=0 -> checkDir=00 only, XPOS stays 6, no right check issued.
REQ-035 GRAVITY_TICKS=4, no user input, canMove=1 -> checkDir=10 every 4 cycles, YPOS increments 0,1,2...
REQ-036 Down check with canMove=0 at YPOS=16 -> landed pulse one cycle, active=0, later moves ignored until spawn.
REQ-037 Reset asserted during REQ -> outputs at reset values same cycle, no position change after release.
